dti_uart_rx_core: RTL and testbench
===================================

DTI_UART_RX_CORE -- requirements
Module: dti_uart_rx_core

Interface
REQ-001 Parameter DATA_W, default 8, data bits per frame, legal 5..9.
REQ-002 Parameter FIFO_DEPTH, default 16, receive FIFO entries, power of two, minimum 4.
REQ-003 Parameter RTS_MARGIN, default 4, free-entry threshold for flow control, range 1..FIFO_DEPTH-1.
REQ-004 Parameter DIV_W, default 16, baud divisor width.
REQ-005 clk  input  1  single clock; all logic is on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 uart_rx  input  1  asynchronous serial line, idles high.
REQ-008 baud_div  input  DIV_W  clk cycles per 16x oversample tick.
REQ-009 parity_en, parity_odd, stop2  input  1 each  frame format: parity enable, odd parity select, two stop bits.
REQ-010 rx_data  output  DATA_W  data field of the FIFO head word.
REQ-011 rx_perr, rx_ferr  output  1 each  parity and framing error flags of the FIFO head word.
REQ-012 rx_valid  output  1  FIFO not empty; rx_ready  input  1  consumer accepts the head word.
REQ-013 rts_n  output  1  flow control, low means the block can accept data.
REQ-014 overrun  output  1  one-cycle pulse when a completed frame is dropped.
REQ-015 break_det  output  1  one-cycle pulse on break detection (see Configuration).

Function
REQ-016 uart_rx SHALL pass through a 2-flop synchroniser whose flops reset to 1; all sampling uses the synchronised value.
REQ-017 Tick counter: a tick SHALL be asserted when the counter reaches max(baud_div,1)-1; the counter then wraps to 0. baud_div=0 SHALL behave as 1.
REQ-018 FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2.
REQ-019 IDLE->START on a synchronised high-to-low transition; baud_div, parity_en, parity_odd and stop2 SHALL be latched at this transition; the tick counter and the sample counter SHALL clear.
REQ-020 START: at sample count 7 the line SHALL be checked; 1 -> IDLE (glitch, nothing pushed); 0 -> DATA.
REQ-021 Each subsequent bit SHALL be sampled once, at sample count 7 of its 16-tick period; data SHALL be received LSB first, DATA_W bits.
REQ-022 PARITY is entered only when parity_en=1; perr=1 when the XOR of data bits and the parity bit does not equal parity_odd.
REQ-023 STOP1 sample 0 SHALL set ferr; STOP2 is entered only when stop2=1 and SHALL OR its own check into ferr.
REQ-024 At the mid-sample of the last stop bit, {ferr, perr, data} SHALL be pushed into the FIFO and the FSM SHALL return to IDLE in the same cycle.
REQ-025 Pop occurs when rx_valid and rx_ready are both 1; rx_data, rx_perr and rx_ferr SHALL show the head word combinationally from FIFO storage.
REQ-026 Push when the FIFO is full and there is no pop: the word is dropped, overrun pulses for one cycle, and the contents are unchanged.
REQ-027 Push and pop in the same cycle while full: both SHALL succeed, the count is unchanged, and overrun stays 0.
REQ-028 Push and pop in the same cycle while empty: the word SHALL be stored and rx_valid SHALL rise on the next cycle; there is no bypass.
REQ-029 rts_n SHALL be registered and equal 1 when count >= FIFO_DEPTH-RTS_MARGIN, else 0.
REQ-030 Push-to-rx_valid latency: 1 clk cycle.

Reset
REQ-031 Reset SHALL force: FSM to IDLE, counters to 0, FIFO empty, rx_valid=0, overrun=0, break_det=0, rts_n=1, synchroniser flops to 1.
REQ-032 Reset asserted mid-frame SHALL discard the partial frame; the next frame SHALL start only after a new falling edge.

Configuration
REQ-033 Macro DTI_UART_RX_BREAK_DET_EN defined: break_det SHALL pulse when a frame has all-zero data, a parity bit of 0 (if enabled) and a first stop bit of 0. The frame SHALL still be pushed with ferr=1. The FSM SHALL then hold in IDLE until the line has been high for one full tick.
REQ-034 Macro undefined: break_det SHALL be tied to 0 and no break logic SHALL be present.

Verification
REQ-035 baud_div=1, 8N1, send 0xA5 -> rx_data=0xA5, perr=0, ferr=0; rx_valid rises 1 cycle after the stop mid-sample (~152 clk after the start edge).
REQ-036 parity_en=1, parity_odd=1, send 0x03 with parity bit 0 -> rx_data=0x03, rx_perr=1.
REQ-037 Stop bit driven 0 on 0x5A -> rx_ferr=1; with DTI_UART_RX_BREAK_DET_EN, send 0x00 with stop 0 -> break_det pulses once.
REQ-038 FIFO_DEPTH=4, RTS_MARGIN=1, rx_ready=0, send 5 frames -> rts_n=1 after the 3rd push, overrun pulses on the 5th, and the first 4 words are intact.
REQ-039 Low glitch of 5 ticks on an idle line -> no push and the FSM returns to IDLE; then a full frame 0x3C -> received correctly.
REQ-040 Reset asserted during DATA of frame 1, then a full frame 0x81 -> exactly one word, 0x81.

Source files
------------

// File: rtl/dti_uart_rx_core_if.sv
// Receive-word stream from the UART core (master) to its consumer (slave).
interface dti_uart_rx_core_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] rx_data;
  logic              rx_perr;
  logic              rx_ferr;
  logic              rx_valid;
  logic              rx_ready;

  modport master (output rx_data, rx_perr, rx_ferr, rx_valid, input rx_ready);
  modport slave  (input rx_data, rx_perr, rx_ferr, rx_valid, output rx_ready);
endinterface

// File: rtl/dti_uart_rx_core.sv
// 16x-oversampling UART receiver with error-tagged receive FIFO and RTS flow control.
// Optional break detection is compiled in with DTI_UART_RX_BREAK_DET_EN.
module dti_uart_rx_core #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int RTS_MARGIN = 4,
  parameter int DIV_W      = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 uart_rx,
  input  logic [DIV_W-1:0]     baud_div,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  input  logic                 stop2,
  dti_uart_rx_core_if.master   rx,
  output logic                 rts_n,
  output logic                 overrun,
  output logic                 break_det
);
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int CW     = AW + 1;
  localparam int WORD_W = DATA_W + 2;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;

  function automatic logic parity_err(input logic [DATA_W-1:0] data, input logic pbit,
                                      input logic odd);
    return (^data ^ pbit) != odd;
  endfunction

  state_t              state_r;
  logic                sync1_r, sync2_r, prev_r;
  logic [1:0]          settle_r;
  logic [DIV_W-1:0]    tick_cnt_r, div_l_r, div_m1_s;
  logic [3:0]          samp_r, bit_r;
  logic [DATA_W-1:0]   data_r;
  logic                perr_r, ferr_r, par_en_l_r, par_odd_l_r, stop2_l_r;
  logic                line_s, tick_s, mid_s, start_s, hold_s;
  logic                push_s, pop_s, full_s, wr_en_s, drop_s;
  logic [WORD_W-1:0]   push_word_s;
  logic [WORD_W-1:0]   mem_r [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr_r, rd_ptr_r;
  logic [CW-1:0]       count_r, count_nx_s;
  logic                rts_n_r, overrun_r;

  assign line_s = sync2_r;

  // Synchroniser; prev_r only arms once real line samples have reached sync2_r.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_r  <= 1'b1;
      sync2_r  <= 1'b1;
      prev_r   <= 1'b0;
      settle_r <= 2'b00;
    end else begin
      sync1_r  <= uart_rx;
      sync2_r  <= sync1_r;
      settle_r <= {settle_r[0], 1'b1};
      prev_r   <= line_s & settle_r[1];
    end
  end

  // Tick compare and sample-point decode.
  always_comb begin
    div_m1_s = '0;
    if (div_l_r == '0) begin
      div_m1_s = '0;
    end else begin
      div_m1_s = div_l_r - DIV_W'(1);
    end
    tick_s  = (tick_cnt_r == div_m1_s);
    mid_s   = tick_s && (samp_r == 4'd7);
    start_s = prev_r && !line_s && !hold_s;
  end

  // Receive FSM with tick/sample/bit counters and per-frame format latch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      tick_cnt_r  <= '0;
      samp_r      <= 4'd0;
      bit_r       <= 4'd0;
      data_r      <= '0;
      perr_r      <= 1'b0;
      ferr_r      <= 1'b0;
      div_l_r     <= '0;
      par_en_l_r  <= 1'b0;
      par_odd_l_r <= 1'b0;
      stop2_l_r   <= 1'b0;
    end else begin
      tick_cnt_r <= tick_s ? '0 : tick_cnt_r + DIV_W'(1);
      if (tick_s) begin
        samp_r <= samp_r + 4'd1;
      end
      case (state_r)
        IDLE: begin
          if (start_s) begin
            state_r     <= START;
            tick_cnt_r  <= '0;
            samp_r      <= 4'd0;
            bit_r       <= 4'd0;
            perr_r      <= 1'b0;
            ferr_r      <= 1'b0;
            div_l_r     <= baud_div;
            par_en_l_r  <= parity_en;
            par_odd_l_r <= parity_odd;
            stop2_l_r   <= stop2;
          end
        end
        START: if (mid_s) state_r <= line_s ? IDLE : DATA;
        DATA: begin
          if (mid_s) begin
            data_r <= {line_s, data_r[DATA_W-1:1]};
            if (bit_r == 4'(DATA_W - 1)) begin
              bit_r   <= 4'd0;
              state_r <= par_en_l_r ? PARITY : STOP1;
            end else begin
              bit_r <= bit_r + 4'd1;
            end
          end
        end
        PARITY: begin
          if (mid_s) begin
            perr_r  <= parity_err(data_r, line_s, par_odd_l_r);
            state_r <= STOP1;
          end
        end
        STOP1: begin
          if (mid_s) begin
            ferr_r  <= ~line_s;
            state_r <= stop2_l_r ? STOP2 : IDLE;
          end
        end
        STOP2: begin
          if (mid_s) begin
            ferr_r  <= ferr_r | ~line_s;
            state_r <= IDLE;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  // Push at the last stop mid-sample; FIFO occupancy bookkeeping.
  always_comb begin
    push_s      = 1'b0;
    push_word_s = '0;
    if (mid_s && ((state_r == STOP1 && !stop2_l_r) || state_r == STOP2)) begin
      push_s      = 1'b1;
      push_word_s = {~line_s | (state_r == STOP2 && ferr_r), perr_r, data_r};
    end else begin
      push_s      = 1'b0;
      push_word_s = '0;
    end
    pop_s   = (count_r != '0) && rx.rx_ready;
    full_s  = (count_r == CW'(FIFO_DEPTH));
    wr_en_s = push_s && (!full_s || pop_s);
    drop_s  = push_s && full_s && !pop_s;
    count_nx_s = count_r;
    if (wr_en_s && !pop_s) begin
      count_nx_s = count_r + CW'(1);
    end else if (pop_s && !wr_en_s) begin
      count_nx_s = count_r - CW'(1);
    end else begin
      count_nx_s = count_r;
    end
  end

  // FIFO storage, pointers, overrun pulse and RTS.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r  <= '0;
      rd_ptr_r  <= '0;
      count_r   <= '0;
      overrun_r <= 1'b0;
      rts_n_r   <= 1'b1;
    end else begin
      if (wr_en_s) begin
        mem_r[wr_ptr_r] <= push_word_s;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      count_r   <= count_nx_s;
      overrun_r <= drop_s;
      rts_n_r   <= (count_nx_s >= CW'(FIFO_DEPTH - RTS_MARGIN));
    end
  end

  assign rx.rx_data  = mem_r[rd_ptr_r][DATA_W-1:0];
  assign rx.rx_perr  = mem_r[rd_ptr_r][DATA_W];
  assign rx.rx_ferr  = mem_r[rd_ptr_r][DATA_W+1];
  assign rx.rx_valid = (count_r != '0);
  assign rts_n       = rts_n_r;
  assign overrun     = overrun_r;

`ifdef DTI_UART_RX_BREAK_DET_EN
  logic pzero_r, hold_r, hold_seen_r, brk_r;

  // Break detect; afterwards block new starts until the line stays high a full tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      pzero_r     <= 1'b1;
      hold_r      <= 1'b0;
      hold_seen_r <= 1'b0;
      brk_r       <= 1'b0;
    end else begin
      brk_r <= 1'b0;
      if (state_r == START) begin
        pzero_r <= 1'b1;
      end else if (state_r == PARITY && mid_s) begin
        pzero_r <= ~line_s;
      end
      if (state_r == STOP1 && mid_s && data_r == '0 && pzero_r && !line_s) begin
        brk_r       <= 1'b1;
        hold_r      <= 1'b1;
        hold_seen_r <= 1'b0;
      end else if (hold_r && state_r == IDLE) begin
        if (!line_s) begin
          hold_seen_r <= 1'b0;
        end else if (tick_s) begin
          if (hold_seen_r) begin
            hold_r <= 1'b0;
          end else begin
            hold_seen_r <= 1'b1;
          end
        end
      end
    end
  end

  assign hold_s    = hold_r;
  assign break_det = brk_r;
`else
  assign hold_s    = 1'b0;
  assign break_det = 1'b0;
`endif
endmodule

// File: tb/tb_dti_uart_rx_core.sv
// Randomized self-checking bench for dti_uart_rx_core (FIFO_DEPTH=4, RTS_MARGIN=1).
module tb_dti_uart_rx_core;
  localparam int DW = 8;
`ifdef DTI_UART_RX_BREAK_DET_EN
  localparam int EXP_BRK = 1;
`else
  localparam int EXP_BRK = 0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        uart_rx;
  logic [15:0] baud_div;
  logic        parity_en, parity_odd, stop2;
  logic        rts_n, overrun, break_det;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          ovr_cnt = 0;
  int          brk_cnt = 0;
  logic [9:0]  exp_q[$];

  dti_uart_rx_core_if #(.DATA_W(DW)) rx_if ();

  dti_uart_rx_core #(.DATA_W(DW), .FIFO_DEPTH(4), .RTS_MARGIN(1), .DIV_W(16)) dut (
    .clk(clk), .reset(reset), .uart_rx(uart_rx), .baud_div(baud_div),
    .parity_en(parity_en), .parity_odd(parity_odd), .stop2(stop2),
    .rx(rx_if.master), .rts_n(rts_n), .overrun(overrun), .break_det(break_det)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (overrun) ovr_cnt <= ovr_cnt + 1;
    if (break_det) brk_cnt <= brk_cnt + 1;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reference: word the receiver must store for a frame, from the line-level view.
  function automatic logic [9:0] model(input logic [7:0] d, input logic pen, input logic podd,
                                       input logic pbit, input logic s1, input logic s2en,
                                       input logic s2b);
    int   ones;
    logic perr, ferr;
    ones = $countones(d) + (pen ? int'(pbit) : 0);
    perr = pen && (podd ? (ones % 2 == 0) : (ones % 2 == 1));
    ferr = (s1 == 1'b0) || (s2en && s2b == 1'b0);
    return {ferr, perr, d};
  endfunction

  task automatic send_frame(input logic [7:0] d, input int div, input logic pen,
                            input logic podd, input logic s2en, input logic pbit,
                            input logic s1, input logic s2b, input logic scramble);
    int bp;
    bp = 16 * ((div == 0) ? 1 : div);
    baud_div   = 16'(div);
    parity_en  = pen;
    parity_odd = podd;
    stop2      = s2en;
    uart_rx    = 1'b0;
    if (scramble) begin
      wait_cyc(8);
      baud_div   = 16'($urandom_range(7, 1));
      parity_en  = 1'($urandom);
      parity_odd = 1'($urandom);
      stop2      = 1'($urandom);
      wait_cyc(bp - 8);
    end else begin
      wait_cyc(bp);
    end
    for (int i = 0; i < 8; i++) begin
      uart_rx = d[i];
      wait_cyc(bp);
    end
    if (pen) begin
      uart_rx = pbit;
      wait_cyc(bp);
    end
    uart_rx = s1;
    wait_cyc(bp);
    if (s2en) begin
      uart_rx = s2b;
      wait_cyc(bp);
    end
    uart_rx = 1'b1;
    wait_cyc(2 * bp);
  endtask

  task automatic drain(input string name);
    logic [9:0] exp_w, got_w;
    int         waited;
    while (exp_q.size() > 0) begin
      exp_w  = exp_q.pop_front();
      waited = 0;
      while (!rx_if.rx_valid && waited < 2000) begin
        wait_cyc(1);
        waited++;
      end
      got_w = {rx_if.rx_ferr, rx_if.rx_perr, rx_if.rx_data};
      n_tests++;
      if (!rx_if.rx_valid) begin
        n_fail++;
        $display("FAIL %s_timeout: rx_valid=0 expected word %h", name, exp_w);
      end else if (got_w !== exp_w) begin
        n_fail++;
        $display("FAIL %s_word: got %h expected %h", name, got_w, exp_w);
      end
      if (rx_if.rx_valid) begin
        rx_if.rx_ready = 1'b1;
        wait_cyc(1);
        rx_if.rx_ready = 1'b0;
      end
    end
    n_tests++;
    if (rx_if.rx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_extra: rx_valid=%b expected 0 after drain", name, rx_if.rx_valid);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    wait_cyc(4);
    n_tests++;
    if ({rx_if.rx_valid, rts_n, overrun, break_det} !== 4'b0100) begin
      n_fail++;
      $display("FAIL reset_outputs: valid,rts_n,ovr,brk=%b expected 0100",
               {rx_if.rx_valid, rts_n, overrun, break_det});
    end
    reset = 1'b0;
    wait_cyc(4);
    n_tests++;
    if (rts_n !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_rts_release: rts_n=%b expected 0", rts_n);
    end
  endtask

  task automatic test_basic();
    int lat;
    lat = 0;
    fork
      send_frame(8'hA5, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      begin
        while (!rx_if.rx_valid && lat < 400) begin
          wait_cyc(1);
          lat++;
        end
      end
    join
    n_tests++;
    if (lat < 148 || lat > 158) begin
      n_fail++;
      $display("FAIL basic_latency: got %0d cycles expected about 152", lat);
    end
    exp_q.push_back(10'h0A5);
    drain("basic_a5");
  endtask

  task automatic test_parity();
    send_frame(8'h03, 1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    exp_q.push_back(10'h103);
    send_frame(8'h07, 2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    exp_q.push_back(10'h007);
    drain("parity");
  endtask

  task automatic test_framing();
    int brk0;
    send_frame(8'h5A, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    exp_q.push_back(10'h25A);
    send_frame(8'hC3, 1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    exp_q.push_back(10'h2C3);
    drain("framing");
    brk0 = brk_cnt;
    send_frame(8'h00, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    exp_q.push_back(10'h200);
    n_tests++;
    if (brk_cnt - brk0 !== EXP_BRK) begin
      n_fail++;
      $display("FAIL break_pulses: got %0d expected %0d", brk_cnt - brk0, EXP_BRK);
    end
    drain("break_word");
    send_frame(8'h96, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    exp_q.push_back(10'h096);
    drain("after_break");
  endtask

  task automatic test_glitch();
    baud_div = 16'd2;
    uart_rx  = 1'b0;
    wait_cyc(10);
    uart_rx = 1'b1;
    wait_cyc(80);
    n_tests++;
    if (rx_if.rx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL glitch_push: rx_valid=%b expected 0", rx_if.rx_valid);
    end
    send_frame(8'h3C, 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    exp_q.push_back(10'h03C);
    drain("glitch_3c");
  endtask

  task automatic test_random();
    logic [7:0] d;
    logic       pen, podd, s2en, pbit, s1, s2b;
    int         div;
    for (int n = 0; n < 10; n++) begin
      d    = 8'($urandom);
      div  = int'($urandom_range(3, 0));
      pen  = 1'($urandom);
      podd = 1'($urandom);
      s2en = 1'($urandom);
      pbit = (podd ? ~(^d) : ^d) ^ ($urandom_range(3, 0) == 0);
      s1   = ($urandom_range(3, 0) != 0) || (d == 8'h00);
      s2b  = ($urandom_range(3, 0) != 0);
      send_frame(d, div, pen, podd, s2en, pbit, s1, s2b, 1'b1);
      exp_q.push_back(model(d, pen, podd, pbit, s1, s2en, s2b));
      drain("random");
    end
  endtask

  task automatic test_fifo_full();
    logic [7:0] d;
    int         ovr0;
    logic       exp_rts;
    ovr0 = ovr_cnt;
    for (int n = 1; n <= 5; n++) begin
      d = 8'($urandom);
      send_frame(d, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      if (n <= 4) exp_q.push_back({2'b00, d});
      exp_rts = (n >= 3);
      n_tests++;
      if (rts_n !== exp_rts) begin
        n_fail++;
        $display("FAIL fifo_rts_%0d: rts_n=%b expected %b", n, rts_n, exp_rts);
      end
      n_tests++;
      if (ovr_cnt - ovr0 !== ((n == 5) ? 1 : 0)) begin
        n_fail++;
        $display("FAIL fifo_overrun_%0d: got %0d pulses expected %0d", n, ovr_cnt - ovr0,
                 (n == 5) ? 1 : 0);
      end
    end
    drain("fifo_full");
    n_tests++;
    if (rts_n !== 1'b0) begin
      n_fail++;
      $display("FAIL fifo_rts_empty: rts_n=%b expected 0", rts_n);
    end
  endtask

  task automatic test_reset_midframe();
    baud_div  = 16'd1;
    parity_en = 1'b0;
    stop2     = 1'b0;
    uart_rx   = 1'b0;
    wait_cyc(24);
    reset = 1'b1;
    wait_cyc(4);
    reset = 1'b0;
    wait_cyc(20);
    uart_rx = 1'b1;
    wait_cyc(64);
    n_tests++;
    if (rx_if.rx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midframe_discard: rx_valid=%b expected 0", rx_if.rx_valid);
    end
    send_frame(8'h81, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    exp_q.push_back(10'h081);
    drain("midframe_81");
  endtask

  initial begin
    reset          = 1'b1;
    uart_rx        = 1'b1;
    baud_div       = 16'd1;
    parity_en      = 1'b0;
    parity_odd     = 1'b0;
    stop2          = 1'b0;
    rx_if.rx_ready = 1'b0;
    wait_cyc(1);
    test_reset();
    test_basic();
    test_parity();
    test_framing();
    test_glitch();
    test_random();
    test_fifo_full();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
